// File: rtl/tilemap_port_arbiter.sv
// rtl/tilemap_port_arbiter.sv - shares the tile map port between requester A (priority) and B
// B is protected from starvation by a saturating counter and may be confined to vertical blank.
module tilemap_port_arbiter #(
  parameter int AW         = 13,
  parameter int DW         = 8,
  parameter int TM_LAT     = 1,
  parameter int STARVE     = 15,
  parameter bit B_VBI_ONLY = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          vbi,
  input  logic          a_req,
  input  logic [AW-1:0] a_adr,
  input  logic [DW-1:0] a_wrt,
  input  logic          a_wen,
  output logic          a_gnt,
  output logic [DW-1:0] a_rdat,
  output logic          a_rvld,
  input  logic          b_req,
  input  logic [AW-1:0] b_adr,
  input  logic [DW-1:0] b_wrt,
  input  logic          b_wen,
  output logic          b_gnt,
  output logic [DW-1:0] b_rdat,
  output logic          b_rvld,
  output logic [AW-1:0] tm_adr,
  output logic [DW-1:0] tm_wrt,
  output logic          tm_wen,
  input  logic [DW-1:0] tm_red
);

  localparam int         DEPTH      = TM_LAT + 1;
  localparam logic [7:0] STARVE_MAX = 8'(STARVE);

  logic             b_elig;
  logic             starve_hit;
  logic [7:0]       sctr_q, sctr_d;
  logic [AW-1:0]    tm_adr_q, tm_adr_d;
  logic [DW-1:0]    tm_wrt_q, tm_wrt_d;
  logic             tm_wen_q, tm_wen_d;
  logic [DEPTH-1:0] trk_vld_q, trk_vld_d;
  logic [DEPTH-1:0] trk_id_q, trk_id_d;
  logic [DW-1:0]    a_rdat_q, a_rdat_d;
  logic [DW-1:0]    b_rdat_q, b_rdat_d;
  logic             a_rvld_q, a_rvld_d;
  logic             b_rvld_q, b_rvld_d;

  // Grants are combinational so a requester can present its next access the cycle after gnt.
  always_comb begin
    b_elig     = b_req && (vbi || !B_VBI_ONLY);
    starve_hit = (sctr_q == STARVE_MAX);
    b_gnt      = !rst && b_elig && (!a_req || starve_hit);
    a_gnt      = !rst && a_req && !b_gnt;
  end

  always_comb begin
    sctr_d = sctr_q;
    if (b_gnt || !b_elig) begin
      sctr_d = '0;
    end else if (a_gnt && !starve_hit) begin
      sctr_d = sctr_q + 8'd1;
    end

    tm_adr_d = tm_adr_q;
    tm_wrt_d = tm_wrt_q;
    tm_wen_d = 1'b0;
    if (a_gnt) begin
      tm_adr_d = a_adr;
      tm_wrt_d = a_wrt;
      tm_wen_d = a_wen;
    end else if (b_gnt) begin
      tm_adr_d = b_adr;
      tm_wrt_d = b_wrt;
      tm_wen_d = b_wen;
    end

    // The last stage lines up with the cycle in which tm_red holds that read's data.
    trk_vld_d = {trk_vld_q[DEPTH-2:0], (a_gnt && !a_wen) || (b_gnt && !b_wen)};
    trk_id_d  = {trk_id_q[DEPTH-2:0], b_gnt};
    a_rvld_d  = trk_vld_q[DEPTH-1] && !trk_id_q[DEPTH-1];
    b_rvld_d  = trk_vld_q[DEPTH-1] && trk_id_q[DEPTH-1];
    a_rdat_d  = a_rvld_d ? tm_red : a_rdat_q;
    b_rdat_d  = b_rvld_d ? tm_red : b_rdat_q;

    if (rst) begin
      sctr_d    = '0;
      tm_adr_d  = '0;
      tm_wrt_d  = '0;
      tm_wen_d  = 1'b0;
      trk_vld_d = '0;
      trk_id_d  = '0;
      a_rvld_d  = 1'b0;
      b_rvld_d  = 1'b0;
      a_rdat_d  = '0;
      b_rdat_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    sctr_q    <= sctr_d;
    tm_adr_q  <= tm_adr_d;
    tm_wrt_q  <= tm_wrt_d;
    tm_wen_q  <= tm_wen_d;
    trk_vld_q <= trk_vld_d;
    trk_id_q  <= trk_id_d;
    a_rvld_q  <= a_rvld_d;
    b_rvld_q  <= b_rvld_d;
    a_rdat_q  <= a_rdat_d;
    b_rdat_q  <= b_rdat_d;
  end

  assign tm_adr = tm_adr_q;
  assign tm_wrt = tm_wrt_q;
  assign tm_wen = tm_wen_q;
  assign a_rvld = a_rvld_q;
  assign b_rvld = b_rvld_q;
  assign a_rdat = a_rdat_q;
  assign b_rdat = b_rdat_q;

endmodule
